// File: rtl/stopwatch_control_unit.sv
// Stopwatch run/stop/clear sequencer with a divided time base and cascaded hh:mm:ss.cc counters.
// o_running and o_tick decode registered state combinationally; o_time is the raw field registers.
module stopwatch_control_unit #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TICK_HZ  = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_runstop,
  input  logic        i_clear,
  output logic [23:0] o_time,
  output logic        o_running,
  output logic        o_tick
);

  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          run;
  logic          clr;
  logic          tick;
  logic [DW-1:0] div_cnt;
  logic [6:0]    msec;
  logic [5:0]    sec;
  logic [5:0]    mins;
  logic [4:0]    hour;
  logic          msec_wrap;
  logic          sec_wrap;
  logic          mins_wrap;
  logic          hour_wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= STOP;
    end else begin
      state <= state_nxt;
    end
  end

  // Clear wins over run/stop only from STOP; RUN ignores clear entirely.
  always_comb begin
    state_nxt = state;
    run       = 1'b0;
    clr       = 1'b0;
    case (state)
      STOP: begin
        if (i_clear) begin
          state_nxt = CLEAR;
        end else if (i_runstop) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        run = 1'b1;
        if (i_runstop) begin
          state_nxt = STOP;
        end
      end
      CLEAR: begin
        clr       = 1'b1;
        state_nxt = STOP;
      end
      default: state_nxt = STOP;
    endcase
  end

  assign tick      = run && (div_cnt == DIV_LAST);
  assign o_tick    = tick;
  assign o_running = run;

  // Divider holds in STOP so a resumed run keeps the partial tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (clr) begin
      div_cnt <= '0;
    end else if (run) begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end
  end

  assign msec_wrap = (msec == 7'd99);
  assign sec_wrap  = (sec  == 6'd59);
  assign mins_wrap = (mins == 6'd59);
  assign hour_wrap = (hour == 5'd23);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msec <= '0;
      sec  <= '0;
      mins <= '0;
      hour <= '0;
    end else if (clr) begin
      msec <= '0;
      sec  <= '0;
      mins <= '0;
      hour <= '0;
    end else if (tick) begin
      msec <= msec_wrap ? 7'd0 : msec + 7'd1;
      if (msec_wrap) begin
        sec <= sec_wrap ? 6'd0 : sec + 6'd1;
        if (sec_wrap) begin
          mins <= mins_wrap ? 6'd0 : mins + 6'd1;
          if (mins_wrap) begin
            hour <= hour_wrap ? 5'd0 : hour + 5'd1;
          end
        end
      end
    end
  end

  assign o_time = {hour, mins, sec, msec};

endmodule

// File: tb/tb_stopwatch_control_unit.sv
// Bench for stopwatch_control_unit with DIV=10: FSM vector table, scoreboarded tick times and time words.
module tb_stopwatch_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_runstop;
  logic        i_clear;
  logic [23:0] o_time;
  logic        o_running;
  logic        o_tick;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_cs = 0;

  typedef struct {
    int          cyc;
    logic [23:0] t;
  } tick_exp_t;

  typedef struct {
    logic rs;
    logic clr;
    logic running;
  } vec_t;

  tick_exp_t   exp_q[$];
  tick_exp_t   cur;
  logic        chk_pend = 1'b0;
  logic [23:0] pend_t;

  stopwatch_control_unit #(.CLK_FREQ(1000), .TICK_HZ(100)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_runstop (i_runstop),
    .i_clear   (i_clear),
    .o_time    (o_time),
    .o_running (o_running),
    .o_tick    (o_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] pack(input int cs);
    int h, m, s, ms;
    h  = (cs / 360000) % 24;
    m  = (cs / 6000) % 60;
    s  = (cs / 100) % 60;
    ms = cs % 100;
    return {5'(h), 6'(m), 6'(s), 7'(ms)};
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Each expected tick carries the cycle it must appear on and the time word after it.
  task automatic push_ticks(input int first, input int n);
    for (int k = 0; k < n; k++) begin
      tick_exp_t e;
      exp_cs++;
      e.cyc = first + 10 * k;
      e.t   = pack(exp_cs);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse(input logic rs, input logic clr);
    i_runstop = rs;
    i_clear   = clr;
    step(1);
    i_runstop = 1'b0;
    i_clear   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
    exp_cs = 0;
  endtask

  always @(negedge clk) begin
    if (chk_pend) begin
      check("tick_time", o_time, pend_t);
      chk_pend = 1'b0;
    end
    if (!reset && o_tick) begin
      if (exp_q.size() == 0) begin
        check("unexpected_tick", 24'd1, 24'd0);
      end else begin
        cur = exp_q.pop_front();
        check("tick_cycle", 24'(cyc), 24'(cur.cyc));
        pend_t   = cur.t;
        chk_pend = 1'b1;
      end
    end
  end

  initial begin
    vec_t        vecs[7];
    int          pre[4];
    int          c;
    int          idle_bad;
    logic [23:0] p;

    vecs[0] = '{1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b0};
    pre[0] = 8639999;
    pre[1] = 359999;
    pre[2] = 5999;
    pre[3] = 12345;

    reset     = 1'b1;
    i_runstop = 1'b0;
    i_clear   = 1'b0;
    step(3);
    check("reset_time", o_time, 24'd0);
    check("reset_running", 24'(o_running), 24'd0);
    check("reset_tick", 24'(o_tick), 24'd0);
    reset = 1'b0;

    idle_bad = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (o_tick !== 1'b0 || o_running !== 1'b0 || o_time !== 24'd0) idle_bad++;
    end
    check("idle_quiet", 24'(idle_bad), 24'd0);

    for (int i = 0; i < 7; i++) begin
      pulse(vecs[i].rs, vecs[i].clr);
      check($sformatf("vec%0d_running", i), 24'(o_running), 24'(vecs[i].running));
      step(1);
    end
    check("vec_time", o_time, 24'd0);

    // Long run: 100 ticks, stop pulse lands on the terminal count of the 100th.
    do_reset();
    c = cyc;
    push_ticks(c + 10, 100);
    pulse(1'b1, 1'b0);
    check("run_running", 24'(o_running), 24'd1);
    step(999);
    pulse(1'b1, 1'b0);
    check("run_1s_time", o_time, pack(100));
    check("run_stopped", 24'(o_running), 24'd0);
    check("stop_no_tick", 24'(o_tick), 24'd0);

    // Partial tick is preserved across a stop.
    pulse(1'b1, 1'b0);
    step(3);
    pulse(1'b1, 1'b0);
    check("partial_stopped", 24'(o_running), 24'd0);
    step(20);
    check("hold_time", o_time, pack(100));
    c = cyc;
    push_ticks(c + 6, 1);
    pulse(1'b1, 1'b0);
    step(7);
    pulse(1'b1, 1'b0);
    check("resume_time", o_time, pack(101));

    // Carry chains from preloaded times.
    for (int i = 0; i < 4; i++) begin
      do_reset();
      p = pack(pre[i]);
      force dut.hour = p[23:19];
      force dut.mins = p[18:13];
      force dut.sec  = p[12:7];
      force dut.msec = p[6:0];
      step(1);
      release dut.hour;
      release dut.mins;
      release dut.sec;
      release dut.msec;
      step(1);
      check($sformatf("preload%0d", i), o_time, p);
      exp_cs = pre[i];
      c = cyc;
      push_ticks(c + 10, 1);
      pulse(1'b1, 1'b0);
      step(9);
      pulse(1'b1, 1'b0);
      check($sformatf("carry%0d", i), o_time, pack(pre[i] + 1));
    end

    // Clear ignored in RUN, clear+runstop in RUN only stops, in STOP clears.
    do_reset();
    c = cyc;
    push_ticks(c + 10, 2);
    pulse(1'b1, 1'b0);
    step(21);
    pulse(1'b0, 1'b1);
    check("clr_in_run", 24'(o_running), 24'd1);
    step(1);
    pulse(1'b1, 1'b1);
    check("both_in_run_running", 24'(o_running), 24'd0);
    check("both_in_run_time", o_time, pack(2));
    step(1);
    pulse(1'b1, 1'b1);
    check("clear_cycle_running", 24'(o_running), 24'd0);
    step(1);
    check("cleared_time", o_time, 24'd0);
    check("cleared_running", 24'(o_running), 24'd0);
    exp_cs = 0;
    c = cyc;
    push_ticks(c + 10, 1);
    pulse(1'b1, 1'b0);
    check("after_clear_run", 24'(o_running), 24'd1);
    step(9);
    pulse(1'b1, 1'b0);
    check("after_clear_time", o_time, pack(1));

    // Asynchronous reset mid-run.
    do_reset();
    c = cyc;
    push_ticks(c + 10, 2);
    pulse(1'b1, 1'b0);
    step(24);
    #2 reset = 1'b1;
    #1;
    check("async_time", o_time, 24'd0);
    check("async_running", 24'(o_running), 24'd0);
    check("async_tick", 24'(o_tick), 24'd0);
    step(3);
    reset = 1'b0;
    step(2);
    check("post_reset_running", 24'(o_running), 24'd0);
    check("post_reset_time", o_time, 24'd0);

    check("pending_ticks", 24'(exp_q.size()), 24'd0);
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_control_unit.md
# stopwatch_control_unit

Run/stop/clear sequencer and time-base datapath for the stopwatch. It turns single-cycle button pulses into a three-state run control and advances cascaded centisecond/second/minute/hour counters from a parameterised tick. It drives the packed 24-bit time word consumed by the FND display controller, together with a status flag.

## Interface
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- TICK_HZ, 100: counter advance rate in Hz. The msec field counts 0..99 in centiseconds.
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; forces every register and output to its reset value.
- i_runstop  input  1  debounced one-cycle pulse; toggles run/stop.
- i_clear  input  1  debounced one-cycle pulse; zeroes time while stopped.
- o_time  output  24  packed time {hour[23:19], min[18:13], sec[12:7], msec[6:0]}; reset 0.
- o_running  output  1  high while in RUN; reset 0.
- o_tick  output  1  one-cycle pulse on each time-base tick; reset 0.

## Operation
- FSM states are STOP, RUN and CLEAR. The reset state is STOP.
- STOP:
  - i_clear=1 -> CLEAR. This has priority when i_clear and i_runstop arrive in the same cycle.
  - Otherwise i_runstop=1 -> RUN.
  - Otherwise stay in STOP.
- RUN:
  - i_runstop=1 -> STOP.
  - i_clear is ignored in RUN, even when simultaneous with i_runstop.
- CLEAR: lasts exactly one cycle, then goes unconditionally to STOP. Any input pulse in the CLEAR cycle is ignored.
- o_running is the registered state decode, equal to (state==RUN).
- Tick divider:
  - Counter width is $clog2(CLK_FREQ/TICK_HZ). It counts 0..DIV-1, where DIV = CLK_FREQ/TICK_HZ.
  - It increments only in RUN.
  - It holds its value in STOP, so a resumed run keeps the partial tick.
  - It is zeroed in CLEAR.
  - At count DIV-1 in RUN it wraps to 0 and o_tick is high for that one cycle.
- Time counters advance only on o_tick. Each field is unsigned binary:
  - msec 0..99; at 99 it wraps to 0 and carries to sec.
  - sec 0..59; at 59 it wraps to 0 on a carry and carries to min.
  - min 0..59; at 59 it wraps to 0 on a carry and carries to hour.
  - hour 0..23; at 23 it wraps to 0 on a carry.
- Full rollover 23:59:59.99 -> 00:00:00.00 happens on a single tick. There is no overflow flag.
- In CLEAR, all four fields are zeroed.
- o_time is the direct concatenation of the field registers, with no extra pipeline stage.

## Timing
- An input pulse sampled at edge N changes the state at edge N. o_running reflects it after edge N, one-cycle latency.
- First tick after entering RUN with divider=0: the divider reaches DIV-1 after DIV RUN cycles. o_tick is high during that cycle, and o_time updates on the same edge the divider wraps. That edge is DIV edges after the run began.
- A stop pulse in the same cycle as a divider terminal count:
  - The tick still occurs: the counter update uses the current state (RUN).
  - The divider wraps to 0, then holds.
- A clear pulse sampled at edge N (from STOP) moves to CLEAR at edge N. o_time=0 and divider=0 after edge N+1. The state is STOP after edge N+1.
- reset asserted mid-run:
  - Immediate asynchronous return to STOP with all counters, the divider, o_time, o_running and o_tick at 0.
  - Deassertion is synchronised externally; the first active edge after deassertion sees STOP.
- Inputs are pulses. A level held high toggles run/stop every cycle, and the bench must not rely on level behaviour.

## Test plan
Use CLK_FREQ=1000 and TICK_HZ=100, so DIV=10.
- Reset then idle 50 cycles -> o_time=0, o_running=0, o_tick never high.
- i_runstop pulse, run 1000 cycles:
  - o_running=1.
  - o_tick pulses every 10 cycles.
  - o_time msec=0, sec=1 (100 ticks).
- Run 4 cycles, pulse i_runstop to stop, wait 20 cycles, resume -> first tick arrives 6 cycles after resume (fraction preserved), and o_time unchanged while stopped.
- Preload hour=23, min=59, sec=59, msec=99 by running, then one tick -> o_time=24'h000000 in one edge.
- While running, pulse i_clear alone and then together with i_runstop:
  - Alone: ignored.
  - Together: stop only, with time retained.
  - Then in STOP, pulse i_clear and i_runstop together -> CLEAR for one cycle, o_time=0, state STOP, o_running=0.
- Assert reset for 3 cycles mid-run at nonzero time -> all outputs 0 asynchronously (before the next edge), and STOP after release.
